// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction-fetch and load/store requests onto a
// byte-wide single-port RAM with a one-cycle read latency.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_if_req/addr     fetch request and byte address (always 4 bytes)
//   i_if_abort        flushes a pending or in-flight fetch
//   o_if_ready/data   one-cycle fetch completion pulse and little-endian word
//   i_mem_req/we/len  load/store request, direction, size (00=1, 01=2, else 4)
//   i_mem_addr/wdata  data byte address and store data
//   o_mem_ready/rdata one-cycle completion pulse and zero-extended load data
//   o_ram_addr/wr/dout registered RAM address, write strobe, write byte
//   i_ram_din         RAM read byte, valid the cycle after its address
//   o_busy            high whenever the controller is not idle
module mem_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_abort,
    output logic        o_if_ready,
    output logic [31:0] o_if_data,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [1:0]  i_mem_len,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic [31:0] o_ram_addr,
    output logic        o_ram_wr,
    output logic [7:0]  o_ram_dout,
    input  logic [7:0]  i_ram_din,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF_RD  = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_len;
    logic [31:0] r_wdata;
    logic [2:0]  r_k;
    logic [31:0] r_asm;
    logic [31:0] r_ram_addr;
    logic        r_ram_wr;
    logic [7:0]  r_ram_dout;
    logic        r_if_ready;
    logic [31:0] r_if_data;
    logic        r_mem_ready;
    logic [31:0] r_mem_rdata;
    logic        r_busy;

    logic [2:0]  w_next_k;
    logic [31:0] w_next_addr;
    logic [31:0] w_asm;
    logic [7:0]  w_wbyte;
    logic [2:0]  w_acc_len;

    assign w_next_k    = r_k + 3'd1;
    assign w_next_addr = r_addr + {29'd0, w_next_k};

    // Size decode of the incoming load/store; the reserved code behaves as a word.
    always_comb begin
        w_acc_len = 3'd4;
        case (i_mem_len)
            2'b00:   w_acc_len = 3'd1;
            2'b01:   w_acc_len = 3'd2;
            default: w_acc_len = 3'd4;
        endcase
    end

    // Assembly register with the byte arriving this cycle merged in. Read data
    // lags its address by one cycle, so while r_k = j the byte for address j-1
    // is on i_ram_din; r_k = 0 means nothing has arrived yet.
    always_comb begin
        w_asm = r_asm;
        case (r_k)
            3'd1:    w_asm[7:0]   = i_ram_din;
            3'd2:    w_asm[15:8]  = i_ram_din;
            3'd3:    w_asm[23:16] = i_ram_din;
            3'd4:    w_asm[31:24] = i_ram_din;
            default: w_asm = r_asm;
        endcase
    end

    // Store byte to present in the next write cycle.
    always_comb begin
        w_wbyte = r_wdata[7:0];
        case (w_next_k[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            2'd3:    w_wbyte = r_wdata[31:24];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_len       <= 3'd0;
            r_wdata     <= 32'd0;
            r_k         <= 3'd0;
            r_asm       <= 32'd0;
            r_ram_addr  <= 32'd0;
            r_ram_wr    <= 1'b0;
            r_ram_dout  <= 8'd0;
            r_if_ready  <= 1'b0;
            r_if_data   <= 32'd0;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_k   <= 3'd0;
                    r_asm <= 32'd0;
                    if (i_mem_req) begin
                        r_addr     <= i_mem_addr;
                        r_len      <= w_acc_len;
                        r_wdata    <= i_mem_wdata;
                        r_ram_addr <= i_mem_addr;
                        r_busy     <= 1'b1;
                        if (i_mem_we) begin
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= i_mem_wdata[7:0];
                            r_state    <= S_MEM_WR;
                        end else begin
                            r_ram_wr   <= 1'b0;
                            r_state    <= S_MEM_RD;
                        end
                    end else if (i_if_req && !i_if_abort) begin
                        r_addr     <= i_if_addr;
                        r_len      <= 3'd4;
                        r_ram_addr <= i_if_addr;
                        r_ram_wr   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_IF_RD;
                    end else begin
                        r_ram_wr   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_IF_RD, S_MEM_RD: begin
                    if (r_state == S_IF_RD && i_if_abort) begin
                        // Flush: drop the partial word without a ready pulse.
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_asm      <= w_asm;
                        r_k        <= w_next_k;
                        r_ram_addr <= w_next_addr;
                        // r_k == N: the last byte is on i_ram_din right now.
                        if (r_k == r_len) begin
                            r_state <= S_DONE;
                            if (r_state == S_IF_RD) begin
                                r_if_ready <= 1'b1;
                                r_if_data  <= w_asm;
                            end else begin
                                r_mem_ready <= 1'b1;
                                r_mem_rdata <= w_asm;
                            end
                        end else begin
                            r_state <= r_state;
                        end
                    end
                end
                S_MEM_WR: begin
                    if (w_next_k == r_len) begin
                        r_ram_wr    <= 1'b0;
                        r_mem_ready <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_k        <= w_next_k;
                        r_ram_addr <= w_next_addr;
                        r_ram_dout <= w_wbyte;
                        r_state    <= S_MEM_WR;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ram_wr <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_if_ready  = r_if_ready;
    assign o_if_data   = r_if_data;
    assign o_mem_ready = r_mem_ready;
    assign o_mem_rdata = r_mem_rdata;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wr    = r_ram_wr;
    assign o_ram_dout  = r_ram_dout;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by randomized
// transactions, checked against a byte-array reference memory.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_abort = 1'b0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_len = 2'b00;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'd0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // ram: what the DUT actually wrote; refm: what the bench says it should hold
    logic [7:0] ram  [logic [31:0]];
    logic [7:0] refm [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_abort(if_abort),
        .o_if_ready(if_ready), .o_if_data(if_data),
        .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_len(mem_len),
        .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
        .o_mem_ready(mem_ready), .o_mem_rdata(mem_rdata),
        .o_ram_addr(ram_addr), .o_ram_wr(ram_wr), .o_ram_dout(ram_dout),
        .i_ram_din(ram_din), .o_busy(busy)
    );

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (refm.exists(a)) return refm[a];
        return dflt(a);
    endfunction

    // Single-port RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        ram_din <= ram_rd(ram_addr);
        if (ram_wr) ram[ram_addr] = ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a]  = d;
        refm[a] = d;
    endtask

    // One load/store started from an idle cycle; returns in the idle cycle after.
    task automatic mem_txn(input logic we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wd);
        int n;
        int rc;
        logic [31:0] exp;
        logic [31:0] a;
        n   = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        rc  = we ? n + 1 : n + 2;
        exp = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (we) refm[a] = wd[8*i +: 8];
            else    exp[8*i +: 8] = ref_rd(a);
        end
        mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
        for (int c = 1; c <= rc + 1; c++) begin
            next_cyc();
            if (c <= rc) chk("mem_busy", {31'd0, busy}, 32'd1);
            if (c <= n) begin
                chk("mem_ram_addr", ram_addr, addr + 32'(c - 1));
                chk("mem_ram_wr", {31'd0, ram_wr}, {31'd0, we});
                if (we) chk("mem_ram_dout", {24'd0, ram_dout}, {24'd0, wd[8*(c-1) +: 8]});
            end else begin
                chk("mem_ram_wr_off", {31'd0, ram_wr}, 32'd0);
            end
            chk("mem_if_ready_quiet", {31'd0, if_ready}, 32'd0);
            if (c == rc) begin
                chk("mem_ready", {31'd0, mem_ready}, 32'd1);
                if (!we) chk("mem_rdata", mem_rdata, exp);
                mem_req = 1'b0;
            end else begin
                chk("mem_ready_quiet", {31'd0, mem_ready}, 32'd0);
            end
            if (c == rc + 1) chk("mem_busy_end", {31'd0, busy}, 32'd0);
        end
    endtask

    // One fetch; abort_at in 1..5 raises if_abort in that cycle (0 = none).
    // with_mem raises mem_req together with the abort.
    task automatic if_txn(input logic [31:0] addr, input int abort_at, input logic with_mem);
        logic [31:0] exp;
        int last;
        for (int i = 0; i < 4; i++) exp[8*i +: 8] = ref_rd(addr + 32'(i));
        last = (abort_at != 0) ? abort_at + 1 : 7;
        if_req = 1'b1; if_addr = addr;
        for (int c = 1; c <= last; c++) begin
            next_cyc();
            if (abort_at != 0 && c == last) begin
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_if_ready", {31'd0, if_ready}, 32'd0);
                chk("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
                if_abort = 1'b0;
            end else begin
                if (c <= 4) chk("if_ram_addr", ram_addr, addr + 32'(c - 1));
                chk("if_ram_wr", {31'd0, ram_wr}, 32'd0);
                chk("if_mem_ready_quiet", {31'd0, mem_ready}, 32'd0);
                if (c <= 6) chk("if_busy", {31'd0, busy}, 32'd1);
                if (c == 6) begin
                    chk("if_ready", {31'd0, if_ready}, 32'd1);
                    chk("if_data", if_data, exp);
                    if_req = 1'b0;
                end else begin
                    chk("if_ready_quiet", {31'd0, if_ready}, 32'd0);
                end
                if (c == 7) chk("if_busy_end", {31'd0, busy}, 32'd0);
                if (c == abort_at) begin
                    if_abort = 1'b1;
                    if_req   = 1'b0;
                    if (with_mem) mem_req = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        int kind;

        // Reset state
        rst = 1'b1;
        next_cyc();
        next_cyc();
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        next_cyc();

        // Fetch of a known instruction word
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        if_txn(32'h100, 0, 1'b0);
        chk("fetch_word", if_data, 32'h0000_0513);

        // Single-byte store then read back
        mem_txn(1'b1, 2'b00, 32'h2000, 32'hAABB_CCDD);
        mem_txn(1'b0, 2'b10, 32'h2000, 32'd0);

        // Contention: memory request wins, fetch follows
        if_req = 1'b1; if_addr = 32'h100;
        mem_txn(1'b0, 2'b10, 32'h40, 32'd0);
        if_txn(32'h100, 0, 1'b0);

        // Abort mid-fetch, then a clean fetch
        if_txn(32'h180, 3, 1'b0);
        if_txn(32'h200, 0, 1'b0);

        // Abort with a load pending in the same cycle
        mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h104; mem_wdata = 32'd0;
        if_txn(32'h300, 5, 1'b1);
        mem_txn(1'b0, 2'b01, 32'h104, 32'd0);

        // Halfword load wrapping past the top of the address space
        preload(32'hFFFF_FFFF, 8'h34); preload(32'h0000_0000, 8'h12);
        mem_txn(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd0);
        chk("wrap_half", mem_rdata, 32'h0000_1234);

        // Byte load is zero-extended; reserved length acts as a word
        mem_txn(1'b0, 2'b00, 32'h101, 32'd0);
        chk("byte_zext", mem_rdata, 32'h0000_0005);
        mem_txn(1'b0, 2'b11, 32'h100, 32'd0);
        chk("len11_word", mem_rdata, 32'h0000_0513);

        // Reset during a word store: only the first byte lands
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10;
        mem_addr = 32'h500; mem_wdata = 32'h1122_3344;
        next_cyc();
        chk("rst_wr_first", {31'd0, ram_wr}, 32'd1);
        rst = 1'b1;
        next_cyc();
        chk("rst_wr_off", {31'd0, ram_wr}, 32'd0);
        chk("rst_wr_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, mem_ready}, 32'd0);
        rst = 1'b0; mem_req = 1'b0;
        next_cyc();
        chk("rst_wr_ready2", {31'd0, mem_ready}, 32'd0);
        refm[32'h500] = 8'h44;
        mem_txn(1'b0, 2'b10, 32'h500, 32'd0);

        // Randomized mix over two small overlapping windows (one wraps)
        for (int t = 0; t < 40; t++) begin
            ra = (($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF8 : 32'h0000_0600)
                 + 32'($urandom_range(0, 15));
            kind = $urandom_range(0, 3);
            case (kind)
                0: mem_txn(1'b1, 2'($urandom_range(0, 3)), ra, $urandom);
                1: mem_txn(1'b0, 2'($urandom_range(0, 3)), ra, 32'd0);
                2: if_txn(ra, 0, 1'b0);
                default: if_txn(ra, $urandom_range(1, 5), 1'b0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
